// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - autobaud detector measuring a 0x55 sync character into a divisor
//
// Purpose:
//   Measures the falling-edge spacing of a 0x55 sync character on the RX line and
//   produces the clock-cycles-per-bit divisor for the UART DIV register.
//   0x55 on the wire (LSB first, with start/stop) gives five falling edges spaced
//   two bit times apart. The first-to-fifth edge span is eight bit times, so the
//   divisor is that span divided by 8, rounded.
//
// Ports:
//   clk_i    in   clock (pclk)
//   rst_n_i  in   asynchronous active-low reset
//   rx_i     in   raw UART RX line, asynchronous
//   start_i  in   single-cycle arm request (ignored while busy_o)
//   abort_i  in   single-cycle cancel, highest priority
//   busy_o   out  high from accepted start until done/err/abort
//   done_o   out  one-cycle pulse, new div_o valid
//   err_o    out  one-cycle pulse, measurement rejected
//   div_o    out  last accepted divisor (cycles per bit)
//
// Optional feature macro: UART_AUTOBAUD_GLITCH_FILTER_EN
//   When defined, a registered 3-sample majority filter follows the synchroniser.
//   Single-cycle glitches are suppressed, and every edge is delayed by 2 cycles.

module uart_autobaud #(
    parameter int DIV_WIDTH   = 16,
    parameter int DIV_MIN     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TOL_SHIFT   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [DIV_WIDTH-1:0] div_o
);

    // The three extra bits hold eight bit times of the largest legal divisor.
    localparam int CW = DIV_WIDTH + 3;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW:0]   DIV_MIN_W = (CW + 1)'(DIV_MIN);
    localparam logic [CW:0]   DIV_MAX_W = {4'b0000, {DIV_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SYNC,
        MEAS,
        CALC,
        FAIL
    } state_t;

    state_t state, state_n;

    // ------------------------------------------------------------------
    // RX synchroniser. The flops reset high because high is the idle line level.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // rx_e is the line level that the edge detector and the FSM observe.
    logic rx_e;

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    logic hist1, hist2, rx_f;

    // The majority of rx_s and its two previous samples is registered, so every
    // transition is delayed by exactly 2 cycles. A lone 1-cycle sample never wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist1 <= 1'b1;
            hist2 <= 1'b1;
            rx_f  <= 1'b1;
        end else begin
            hist1 <= rx_s;
            hist2 <= hist1;
            rx_f  <= (rx_s & hist1) | (rx_s & hist2) | (hist1 & hist2);
        end
    end

    assign rx_e = rx_f;
`else
    assign rx_e = rx_s;
`endif

    logic rx_d;
    logic fall;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_d <= 1'b1;
        end else begin
            rx_d <= rx_e;
        end
    end

    assign fall = rx_d & ~rx_e;

    // ------------------------------------------------------------------
    // Measurement datapath
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_mark;
    logic [CW-1:0] ref_int;
    logic [CW-1:0] total;
    logic [2:0]    edge_idx;

    // cnt is cleared in the cycle after the start-bit edge, so cnt+1 equals the
    // number of cycles elapsed since that edge.
    logic [CW-1:0] now_t;
    logic [CW-1:0] interval;
    logic [CW-1:0] diff;
    logic [CW-1:0] tol;
    logic [CW:0]   sum_r;
    logic [CW:0]   div_calc;
    logic          div_ok;

    assign now_t    = cnt + 1'b1;
    assign interval = now_t - last_mark;
    assign diff     = (interval >= ref_int) ? (interval - ref_int) : (ref_int - interval);
    assign tol      = ref_int >> TOL_SHIFT;
    assign sum_r    = {1'b0, total} + (CW + 1)'(4);
    assign div_calc = sum_r >> 3;
    assign div_ok   = (div_calc >= DIV_MIN_W) && (div_calc <= DIV_MAX_W);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt       <= '0;
            last_mark <= '0;
            ref_int   <= '0;
            total     <= '0;
            edge_idx  <= '0;
            div_o     <= DIV_WIDTH'(DIV_MIN);
        end else begin
            case (state)
                SYNC: begin
                    if (fall) begin
                        cnt       <= '0;
                        last_mark <= '0;
                        edge_idx  <= '0;
                    end
                end
                MEAS: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (fall) begin
                        last_mark <= now_t;
                        edge_idx  <= edge_idx + 3'd1;
                        if (edge_idx == 3'd0) begin
                            ref_int <= interval;
                        end
                        total <= now_t;
                    end
                end
                CALC: begin
                    if (div_ok && !abort_i) begin
                        div_o <= div_calc[DIV_WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic busy_n, done_n, err_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            state  <= state_n;
            busy_o <= busy_n;
            done_o <= done_n;
            err_o  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        busy_n  = busy_o;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (abort_i) begin
            state_n = IDLE;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state_n = ARM;
                        busy_n  = 1'b1;
                    end
                end
                // A high line must be seen first, so that the first falling edge
                // can only be a start bit and not an edge in the middle of a frame.
                ARM: begin
                    if (rx_e) begin
                        state_n = SYNC;
                    end
                end
                SYNC: begin
                    if (fall) begin
                        state_n = MEAS;
                    end
                end
                MEAS: begin
                    if (cnt == CNT_MAX) begin
                        state_n = FAIL;
                    end else if (fall) begin
                        if ((edge_idx != 3'd0) && (diff > tol)) begin
                            state_n = FAIL;
                        end else if (edge_idx == 3'd3) begin
                            state_n = CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_ok) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = FAIL;
                    end
                end
                FAIL: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    err_n   = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb/tb_uart_autobaud.sv - self-checking bench for uart_autobaud with directed vectors

module tb_uart_autobaud;

    // A narrow divisor keeps the counter-saturation case within a short run.
    localparam int DW = 10;
    localparam int DMIN = 2;

    logic          clk;
    logic          rst_n;
    logic          rx;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] div;

    int checks;
    int errors;
    int cur_div;

    uart_autobaud #(
        .DIV_WIDTH  (DW),
        .DIV_MIN    (DMIN),
        .SYNC_STAGES(2),
        .TOL_SHIFT  (2)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .rx_i   (rx),
        .start_i(start),
        .abort_i(abort),
        .busy_o (busy),
        .done_o (done),
        .err_o  (err),
        .div_o  (div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n;
        int f[6];
        int w[6];
        bit exp_err;
        int exp_div;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk55(input int p);
        vec_t v;
        v.n = 5;
        for (int i = 0; i < 6; i++) begin
            v.f[i] = (i < 5) ? i * 2 * p : 0;
            v.w[i] = (i < 5) ? p : 0;
        end
        v.exp_err = 1'b0;
        v.exp_div = p;
        return v;
    endfunction

    function automatic vec_t mkv(input int n, input int f0, input int f1, input int f2,
                                 input int f3, input int f4, input int f5, input int wd,
                                 input bit e, input int d);
        vec_t v;
        v.n = n;
        v.f[0] = f0; v.f[1] = f1; v.f[2] = f2;
        v.f[3] = f3; v.f[4] = f4; v.f[5] = f5;
        for (int i = 0; i < 6; i++) v.w[i] = wd;
        v.exp_err = e;
        v.exp_div = d;
        return v;
    endfunction

    // The line is low whenever t lies inside one of the [f, f+w) windows.
    task automatic run_vec(input vec_t v, input string name);
        int last_end;
        int nd;
        int ne;
        logic lvl;
        last_end = 0;
        for (int i = 0; i < v.n; i++)
            if (v.f[i] + v.w[i] > last_end) last_end = v.f[i] + v.w[i];
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        nd = 0;
        ne = 0;
        for (int t = 0; t < last_end + 24; t++) begin
            @(negedge clk);
            if (done) nd++;
            if (err) ne++;
            lvl = 1'b1;
            for (int i = 0; i < v.n; i++)
                if (t >= v.f[i] && t < v.f[i] + v.w[i]) lvl = 1'b0;
            rx = lvl;
        end
        if (!v.exp_err) cur_div = v.exp_div;
        check({name, "_done"}, nd, v.exp_err ? 0 : 1);
        check({name, "_err"}, ne, v.exp_err ? 1 : 0);
        check({name, "_div"}, int'(div), cur_div);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int nd;
        int ne;
        int waited;
        bit seen;
        checks  = 0;
        errors  = 0;
        cur_div = DMIN;
        rx      = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        rst_n   = 1'b0;

        vecs[0] = mk55(16);
        vecs[1] = mkv(3, 0, 32, 128, 0, 0, 0, 16, 1'b1, 0);
        vecs[1].w[1] = 80;
        vecs[2] = mkv(5, 0, 211, 413, 626, 829, 0, 104, 1'b0, 104);
        vecs[3] = mkv(5, 0, 32, 72, 104, 128, 0, 16, 1'b0, 16);
        vecs[4] = mkv(5, 0, 32, 73, 105, 129, 0, 16, 1'b1, 0);
        vecs[5] = mkv(5, 0, 2045, 4090, 6135, 8180, 0, 1000, 1'b0, 1023);
        vecs[6] = mkv(5, 0, 2047, 4094, 6141, 8188, 0, 1000, 1'b1, 0);
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
        vecs[7] = mkv(6, 0, 24, 32, 64, 96, 128, 16, 1'b0, 16);
        vecs[7].w[1] = 1;
        vecs[8] = mk55(2);
`else
        vecs[7] = mkv(6, 0, 24, 32, 64, 96, 128, 16, 1'b1, 0);
        vecs[7].w[1] = 1;
        vecs[8] = mkv(5, 0, 2, 4, 6, 8, 0, 1, 1'b1, 0);
`endif

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_div", int'(div), DMIN);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Start and abort together in IDLE: the block stays idle.
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("start_abort_busy", int'(busy), 0);

        // Abort after the third falling edge of a 0x55 at 16 cycles per bit.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        nd = 0;
        ne = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (done) nd++;
            if (err) ne++;
            if (t == 72) check("abort_busy_before", int'(busy), 1);
            if (t == 74) check("abort_busy_after", int'(busy), 0);
            abort = (t == 73);
            rx = (t < 160 && ((t / 16) % 2 == 0)) ? 1'b0 : 1'b1;
        end
        check("abort_done", nd, 0);
        check("abort_err", ne, 0);
        check("abort_div", int'(div), cur_div);
        run_vec(vecs[2], "restart");

        // No edges: the counter must not run. Then one falling edge held low.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ne = 0;
        for (int t = 0; t < 8292; t++) begin
            @(negedge clk);
            if (err) ne++;
        end
        check("idle_line_busy", int'(busy), 1);
        check("idle_line_err", ne, 0);
        rx = 1'b0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 9000) begin
            @(negedge clk);
            waited++;
            if (err) seen = 1'b1;
        end
        check("timeout_err", int'(seen), 1);
        check("timeout_div", int'(div), cur_div);
        @(negedge clk);
        check("timeout_busy", int'(busy), 0);
        rx = 1'b1;

        // Asynchronous reset in the middle of a measurement.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            rx = ((t / 16) % 2 == 0) ? 1'b0 : 1'b1;
        end
        check("midrst_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_div", int'(div), DMIN);
        rx = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cur_div = DMIN;
        run_vec(vecs[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
